// File: rtl/wb_arb_pkg.sv
// Shared definitions for the Wishbone bus arbiter.
// CTI codes, FSM encoding and a one-hot helper.
package wb_arb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef enum logic {
        ST_IDLE,
        ST_OWN
    } state_t;

    // Index of the set bit in a one-hot vector (0 when empty).
    function automatic logic [1:0] oh_index(input logic [3:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Round-robin picker: first requester at or above ptr,
// wrapping modulo NUM, returned as a one-hot grant.
module wb_rr_pick #(
    parameter int NUM = 2,
    parameter int PW  = 1
) (
    input  logic [NUM-1:0] req,
    input  logic [PW-1:0]  ptr,
    output logic [NUM-1:0] gnt
);

    logic          found;
    logic [PW-1:0] idx;

    // Scan upward from the pointer, take the first requester.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM; i++) begin
            idx = PW'((int'(ptr) + i) % NUM);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Round-robin Wishbone arbiter sharing one slave among
// NUM masters, with a per-transfer ACK watchdog.
module wb_bus_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM     = 2,
    parameter int WIDTH   = 16,
    parameter int ADDRESS = 25,
    parameter int TIMEOUT = 64,
    parameter int HIGHZ   = 0
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_ni,
    input  logic [NUM-1:0]            m_cyc_i,
    input  logic [NUM-1:0]            m_stb_i,
    input  logic [NUM-1:0]            m_we_i,
    input  logic [3*NUM-1:0]          m_cti_i,
    input  logic [ADDRESS*NUM-1:0]    m_adr_i,
    input  logic [(WIDTH/8)*NUM-1:0]  m_sel_i,
    input  logic [WIDTH*NUM-1:0]      m_dat_i,
    output logic [NUM-1:0]            m_ack_o,
    output logic [NUM-1:0]            m_err_o,
    output logic [WIDTH-1:0]          m_dat_o,
    output logic                      s_cyc_o,
    output logic                      s_stb_o,
    output logic                      s_we_o,
    output logic [2:0]                s_cti_o,
    output logic [ADDRESS-1:0]        s_adr_o,
    output logic [WIDTH/8-1:0]        s_sel_o,
    output logic [WIDTH-1:0]          s_dat_o,
    input  logic [WIDTH-1:0]          s_dat_i,
    input  logic                      s_ack_i,
    input  logic                      s_err_i,
    output logic [NUM-1:0]            gnt_o
);

    localparam int SELW = WIDTH / 8;
    localparam int PW   = (NUM > 1) ? $clog2(NUM) : 1;
    localparam int CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WD_LAST =
        (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    state_t             state, state_n;
    logic [NUM-1:0]     gnt_n, pick;
    logic [PW-1:0]      ptr, ptr_n, owner;
    logic [CW-1:0]      wd;
    logic [3:0]         gnt4;
    logic               own, own_cyc, stb_raw, timeout;
    logic               we_mux;
    logic [2:0]         cti_mux;
    logic [ADDRESS-1:0] adr_mux;
    logic [SELW-1:0]    sel_mux;
    logic [WIDTH-1:0]   dat_mux;

    wb_rr_pick #(.NUM(NUM), .PW(PW)) u_pick (
        .req (m_cyc_i),
        .ptr (ptr),
        .gnt (pick)
    );

    // Owner index derived from the registered one-hot grant.
    always_comb begin
        gnt4           = '0;
        gnt4[NUM-1:0]  = gnt_o;
        owner          = PW'(oh_index(gnt4));
    end

    assign own     = (state == ST_OWN);
    assign own_cyc = own & m_cyc_i[owner];
    assign stb_raw = own_cyc & m_stb_i[owner];
    assign timeout = (TIMEOUT != 0) && stb_raw && !s_ack_i
                     && !s_err_i && (wd == WD_LAST);

    assign s_cyc_o = own_cyc;
    assign s_stb_o = stb_raw & ~timeout;
    assign m_ack_o = gnt_o & {NUM{s_ack_i}};
    assign m_err_o = gnt_o & {NUM{s_err_i | timeout}};
    assign m_dat_o = s_dat_i;

    // Select the owner's request payload.
    always_comb begin
        we_mux  = m_we_i[owner];
        cti_mux = m_cti_i[owner*3 +: 3];
        adr_mux = m_adr_i[owner*ADDRESS +: ADDRESS];
        sel_mux = m_sel_i[owner*SELW +: SELW];
        dat_mux = m_dat_i[owner*WIDTH +: WIDTH];
    end

    if (HIGHZ != 0) begin : g_hiz
        assign s_we_o  = own ? we_mux  : 1'bz;
        assign s_cti_o = own ? cti_mux : 3'bzzz;
        assign s_adr_o = own ? adr_mux : {ADDRESS{1'bz}};
        assign s_sel_o = own ? sel_mux : {SELW{1'bz}};
        assign s_dat_o = own ? dat_mux : {WIDTH{1'bz}};
    end else begin : g_zero
        assign s_we_o  = own & we_mux;
        assign s_cti_o = own ? cti_mux : CTI_CLASSIC;
        assign s_adr_o = own ? adr_mux : '0;
        assign s_sel_o = own ? sel_mux : '0;
        assign s_dat_o = own ? dat_mux : '0;
    end

    // Watchdog: count strobed cycles without termination.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni)
            wd <= '0;
        else if (!stb_raw || s_ack_i || s_err_i || timeout)
            wd <= '0;
        else
            wd <= wd + 1'b1;
    end

    // State, grant and priority pointer registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state <= ST_IDLE;
            gnt_o <= '0;
            ptr   <= '0;
        end else begin
            state <= state_n;
            gnt_o <= gnt_n;
            ptr   <= ptr_n;
        end
    end

    // Grant on any CYC in IDLE; release when owner drops CYC.
    always_comb begin
        state_n = state;
        gnt_n   = gnt_o;
        ptr_n   = ptr;
        case (state)
            ST_IDLE: begin
                if (|m_cyc_i) begin
                    state_n = ST_OWN;
                    gnt_n   = pick;
                end
            end
            ST_OWN: begin
                if (!own_cyc) begin
                    state_n = ST_IDLE;
                    gnt_n   = '0;
                    ptr_n   = (owner == PW'(NUM - 1)) ?
                              '0 : owner + 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                gnt_n   = '0;
            end
        endcase
    end

endmodule
